// File: rtl/kpn_read_port.sv
// Blocking-read port: pops a requested number of tokens from a fifo_module head
// and presents them to the process over valid/ready, with saturating statistics.
module kpn_read_port #(
  parameter int unsigned BITS_NUMBER   = 16,
  parameter int unsigned FIFO_ELEMENTS = 5,
  parameter int unsigned STAT_BITS     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [BITS_NUMBER-1:0]   fifo_data,
  input  logic                     fifo_empty,
  output logic                     fifo_rd,
  input  logic                     req,
  input  logic [FIFO_ELEMENTS:0]   req_len,
  output logic                     busy,
  output logic                     done,
  output logic [BITS_NUMBER-1:0]   token_data,
  output logic                     token_valid,
  input  logic                     token_ready,
  input  logic                     stat_clr,
  output logic [STAT_BITS-1:0]     tokens_read,
  output logic [STAT_BITS-1:0]     blocked_cycles
);

  localparam int unsigned LEN_W = FIFO_ELEMENTS + 1;
  localparam logic [LEN_W-1:0]     LEN_ZERO  = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0]     LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [STAT_BITS-1:0] STAT_ZERO = {STAT_BITS{1'b0}};
  localparam logic [STAT_BITS-1:0] STAT_ONE  = {{(STAT_BITS-1){1'b0}}, 1'b1};
  localparam logic [STAT_BITS-1:0] STAT_MAX  = {STAT_BITS{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e                 state_q;
  logic [LEN_W-1:0]       remaining_q;
  logic [BITS_NUMBER-1:0] token_data_q;
  logic                   token_valid_q;
  logic                   busy_q;
  logic                   done_q;
  logic [STAT_BITS-1:0]   tokens_read_q;
  logic [STAT_BITS-1:0]   tokens_read_d;
  logic [STAT_BITS-1:0]   blocked_q;
  logic [STAT_BITS-1:0]   blocked_d;

  logic pop_s;
  logic accept_s;
  logic blocked_s;

  function automatic logic [STAT_BITS-1:0] sat_inc(input logic [STAT_BITS-1:0] v,
                                                   input logic inc);
    if (inc && (v != STAT_MAX)) begin
      return v + STAT_ONE;
    end else begin
      return v;
    end
  endfunction

  // Never pop an empty FIFO: its pointers corrupt on a read while empty.
  always_comb begin
    pop_s     = (state_q == ST_READ) && !fifo_empty && (remaining_q != LEN_ZERO) &&
                (!token_valid_q || token_ready);
    accept_s  = token_valid_q && token_ready;
    blocked_s = (state_q == ST_READ) && (remaining_q != LEN_ZERO) && fifo_empty;
  end

  // Clear has priority over a same-cycle increment.
  always_comb begin
    if (stat_clr) begin
      tokens_read_d = STAT_ZERO;
      blocked_d     = STAT_ZERO;
    end else begin
      tokens_read_d = sat_inc(tokens_read_q, pop_s);
      blocked_d     = sat_inc(blocked_q, blocked_s);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      remaining_q   <= LEN_ZERO;
      token_data_q  <= {BITS_NUMBER{1'b0}};
      token_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            if (req_len != LEN_ZERO) begin
              remaining_q <= req_len;
              state_q     <= ST_READ;
              busy_q      <= 1'b1;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (pop_s) begin
            token_data_q  <= fifo_data;
            token_valid_q <= 1'b1;
            remaining_q   <= remaining_q - LEN_ONE;
            if (remaining_q == LEN_ONE) begin
              state_q <= ST_DRAIN;
            end
          end else if (accept_s) begin
            token_valid_q <= 1'b0;
          end
        end
        ST_DRAIN: begin
          // Finish once the final token has left the output register.
          if (!token_valid_q || accept_s) begin
            token_valid_q <= 1'b0;
            state_q       <= ST_IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b1;
          end
        end
        default: begin
          state_q       <= ST_IDLE;
          remaining_q   <= LEN_ZERO;
          token_valid_q <= 1'b0;
          busy_q        <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tokens_read_q <= STAT_ZERO;
      blocked_q     <= STAT_ZERO;
    end else begin
      tokens_read_q <= tokens_read_d;
      blocked_q     <= blocked_d;
    end
  end

  assign fifo_rd        = pop_s;
  assign busy           = busy_q;
  assign done           = done_q;
  assign token_data     = token_data_q;
  assign token_valid    = token_valid_q;
  assign tokens_read    = tokens_read_q;
  assign blocked_cycles = blocked_q;

endmodule

// File: tb/tb_kpn_read_port.sv
// Bench for kpn_read_port: queue-based FIFO and transaction model checked every
// cycle, a scenario table, hand-written corner sequences and a random phase.
module tb_kpn_read_port;

  typedef struct {
    int len;
    int pre;
    int mode;
    int gap;
    int et;
    int eb;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [15:0] fifo_data;
  logic fifo_empty;
  logic fifo_rd;
  logic req;
  logic [5:0] req_len;
  logic busy;
  logic done;
  logic [15:0] token_data;
  logic token_valid;
  logic token_ready;
  logic stat_clr;
  logic [15:0] tokens_read;
  logic [15:0] blocked_cycles;

  logic [15:0] fifo_data2 = 16'h5A5A;
  logic fifo_empty2;
  logic fifo_rd2;
  logic req2;
  logic [5:0] req_len2;
  logic busy2;
  logic done2;
  logic [15:0] token_data2;
  logic token_valid2;
  logic token_ready2 = 1'b1;
  logic stat_clr2 = 1'b0;
  logic [3:0] tokens_read2;
  logic [3:0] blocked2;

  int checks = 0;
  int errors = 0;

  logic [15:0] fq[$];
  logic [15:0] m_hold[$];
  bit m_active;
  int m_out;
  int m_tok;
  int m_blk;
  bit m_done;

  vec_t vecs[7];

  always #5 clk = ~clk;

  kpn_read_port #(.BITS_NUMBER(16), .FIFO_ELEMENTS(5), .STAT_BITS(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_rd(fifo_rd), .req(req), .req_len(req_len), .busy(busy), .done(done),
    .token_data(token_data), .token_valid(token_valid), .token_ready(token_ready),
    .stat_clr(stat_clr), .tokens_read(tokens_read), .blocked_cycles(blocked_cycles)
  );

  kpn_read_port #(.BITS_NUMBER(16), .FIFO_ELEMENTS(5), .STAT_BITS(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .fifo_data(fifo_data2), .fifo_empty(fifo_empty2),
    .fifo_rd(fifo_rd2), .req(req2), .req_len(req_len2), .busy(busy2), .done(done2),
    .token_data(token_data2), .token_valid(token_valid2), .token_ready(token_ready2),
    .stat_clr(stat_clr2), .tokens_read(tokens_read2), .blocked_cycles(blocked2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void fifo_drive();
    fifo_empty = (fq.size() == 0);
    fifo_data  = (fq.size() == 0) ? 16'h0000 : fq[0];
  endfunction

  function automatic void model_reset();
    m_hold.delete();
    m_active = 1'b0;
    m_out    = 0;
    m_tok    = 0;
    m_blk    = 0;
    m_done   = 1'b0;
  endfunction

  function automatic logic [15:0] tok_val(input int vi, input int i);
    return 16'((vi << 8) + (i + 1) * 17);
  endfunction

  // One clock: predict from the rules before the edge, update the model after it.
  task automatic tick();
    bit live = 1'b0;
    bit exp_pop = 1'b0;
    bit acc = 1'b0;
    bit blk = 1'b0;
    bit start = 1'b0;
    bit done_n = 1'b0;
    bit complete = 1'b0;
    bit clr = 1'b0;
    int len = 0;
    @(negedge clk);
    live = (rst_n === 1'b1);
    if (live) begin
      exp_pop  = m_active && (m_out != 0) && (fq.size() != 0) &&
                 ((m_hold.size() == 0) || token_ready);
      acc      = (m_hold.size() != 0) && token_ready;
      blk      = m_active && (m_out != 0) && (fq.size() == 0);
      start    = !m_active && req && (req_len != 6'd0);
      done_n   = !m_active && req && (req_len == 6'd0);
      complete = m_active && (m_out == 0) && ((m_hold.size() == 0) || acc);
      clr      = stat_clr;
      len      = int'(req_len);
      chk("fifo_rd", 32'(fifo_rd), 32'(exp_pop));
      if (m_hold.size() != 0) begin
        chk("token_data", 32'(token_data), 32'(m_hold[0]));
      end
    end
    @(posedge clk);
    #1;
    if (live && rst_n) begin
      if (acc) void'(m_hold.pop_front());
      if (exp_pop) begin
        m_hold.push_back(fq.pop_front());
        m_out--;
      end
      fifo_drive();
      if (clr) begin
        m_tok = 0;
        m_blk = 0;
      end else begin
        if (exp_pop && m_tok < 65535) m_tok++;
        if (blk && m_blk < 65535) m_blk++;
      end
      if (complete) m_active = 1'b0;
      if (start) begin
        m_active = 1'b1;
        m_out    = len;
      end
      m_done = done_n || complete;
      chk("busy", 32'(busy), 32'(m_active));
      chk("done", 32'(done), 32'(m_done));
      chk("token_valid", 32'(token_valid), 32'(m_hold.size() != 0));
      chk("tokens_read", 32'(tokens_read), 32'(m_tok));
      chk("blocked_cycles", 32'(blocked_cycles), 32'(m_blk));
    end
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  task automatic clear_stats();
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int vi);
    int nval = 0;
    int to_push;
    int wait_cnt = 0;
    bit seen = 1'b0;
    clear_stats();
    for (int i = 0; i < v.pre; i++) begin
      fq.push_back(tok_val(vi, nval));
      nval++;
    end
    fifo_drive();
    to_push     = v.len - v.pre;
    token_ready = 1'b1;
    req         = 1'b1;
    req_len     = 6'(v.len);
    tick();
    req = 1'b0;
    for (int c = 0; c < 600; c++) begin
      case (v.mode)
        0:       token_ready = 1'b1;
        1:       token_ready = (c % 2 == 1);
        default: token_ready = ($urandom_range(0, 1) == 1);
      endcase
      if (to_push > 0 && fq.size() == 0) begin
        if (wait_cnt == v.gap) begin
          fq.push_back(tok_val(vi, nval));
          nval++;
          to_push--;
          wait_cnt = 0;
          fifo_drive();
        end else begin
          wait_cnt++;
        end
      end
      tick();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk($sformatf("vec%0d_done", vi), 32'(seen), 32'd1);
    chk($sformatf("vec%0d_tokens", vi), 32'(tokens_read), 32'(v.et));
    chk($sformatf("vec%0d_blocked", vi), 32'(blocked_cycles), 32'(v.eb));
    chk($sformatf("vec%0d_fifo_left", vi), 32'(fq.size()), 32'd0);
  endtask

  task automatic run_small(input int len);
    bit seen = 1'b0;
    req2     = 1'b1;
    req_len2 = 6'(len);
    tick();
    req2 = 1'b0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (done2) begin
        seen = 1'b1;
        break;
      end
    end
    chk("sat_done", 32'(seen), 32'd1);
  endtask

  initial begin
    vecs[0] = '{len: 3,  pre: 3,  mode: 0, gap: 0, et: 3,  eb: 0};
    vecs[1] = '{len: 4,  pre: 4,  mode: 1, gap: 0, et: 4,  eb: 0};
    vecs[2] = '{len: 5,  pre: 0,  mode: 0, gap: 2, et: 5,  eb: 10};
    vecs[3] = '{len: 6,  pre: 2,  mode: 1, gap: 1, et: 6,  eb: 4};
    vecs[4] = '{len: 1,  pre: 1,  mode: 2, gap: 0, et: 1,  eb: 0};
    vecs[5] = '{len: 20, pre: 5,  mode: 2, gap: 0, et: 20, eb: 0};
    vecs[6] = '{len: 63, pre: 0,  mode: 0, gap: 1, et: 63, eb: 63};

    rst_n = 1'b0; req = 1'b0; req_len = 6'd0; token_ready = 1'b0; stat_clr = 1'b0;
    req2 = 1'b0; req_len2 = 6'd0; fifo_empty2 = 1'b0;
    fq.delete();
    fifo_drive();
    model_reset();
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(token_valid), 32'd0);
    chk("rst_data", 32'(token_data), 32'd0);
    chk("rst_fifo_rd", 32'(fifo_rd), 32'd0);
    chk("rst_tokens", 32'(tokens_read), 32'd0);
    chk("rst_blocked", 32'(blocked_cycles), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Blocking read: 5 empty cycles, one token, 3 empty cycles, one token.
    clear_stats();
    token_ready = 1'b1;
    req = 1'b1; req_len = 6'd2;
    tick();
    req = 1'b0;
    repeat (5) tick();
    fq.push_back(16'h00AA); fifo_drive();
    tick();
    repeat (3) tick();
    fq.push_back(16'h00BB); fifo_drive();
    wait_done("block_done");
    chk("block_blocked", 32'(blocked_cycles), 32'd8);
    chk("block_tokens", 32'(tokens_read), 32'd2);

    // Zero-length request with data present: done next cycle, nothing popped.
    fq.push_back(16'h1234); fifo_drive();
    req = 1'b1; req_len = 6'd0;
    tick();
    req = 1'b0;
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    tick();
    chk("zero_done_drop", 32'(done), 32'd0);
    chk("zero_fifo_left", 32'(fq.size()), 32'd1);
    fq.delete(); fifo_drive();

    // A second request while busy is dropped.
    clear_stats();
    for (int i = 0; i < 4; i++) fq.push_back(tok_val(9, i));
    fifo_drive();
    req = 1'b1; req_len = 6'd2;
    tick();
    req_len = 6'd5;
    repeat (2) tick();
    req = 1'b0;
    wait_done("ignore_done");
    chk("ignore_tokens", 32'(tokens_read), 32'd2);
    chk("ignore_fifo_left", 32'(fq.size()), 32'd2);
    fq.delete(); fifo_drive();

    // Reset after two of five tokens have been popped.
    clear_stats();
    for (int i = 0; i < 5; i++) fq.push_back(tok_val(10, i));
    fifo_drive();
    req = 1'b1; req_len = 6'd5;
    tick();
    req = 1'b0;
    repeat (2) tick();
    chk("mid_popped", 32'(fq.size()), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_fifo_rd", 32'(fifo_rd), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_valid", 32'(token_valid), 32'd0);
    chk("mid_data", 32'(token_data), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_tokens", 32'(tokens_read), 32'd0);
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    chk("mid_fifo_intact", 32'(fq.size()), 32'd3);
    req = 1'b1; req_len = 6'd3;
    tick();
    req = 1'b0;
    wait_done("mid_drain_done");
    chk("mid_drain_tokens", 32'(tokens_read), 32'd3);

    // Clear coincident with a pop.
    for (int i = 0; i < 2; i++) fq.push_back(tok_val(11, i));
    fifo_drive();
    req = 1'b1; req_len = 6'd2;
    tick();
    req = 1'b0;
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("clr_pop", 32'(tokens_read), 32'd0);
    tick();
    chk("clr_after", 32'(tokens_read), 32'd1);
    wait_done("clr_done");

    // Saturation on the 4-bit instance: 14 then 3 pops, then a long block.
    run_small(14);
    chk("sat_pre", 32'(tokens_read2), 32'd14);
    run_small(3);
    chk("sat_tokens", 32'(tokens_read2), 32'd15);
    fifo_empty2 = 1'b1;
    req2 = 1'b1; req_len2 = 6'd1;
    tick();
    req2 = 1'b0;
    repeat (20) tick();
    chk("sat_no_rd", 32'(fifo_rd2), 32'd0);
    chk("sat_blocked", 32'(blocked2), 32'd15);
    fifo_empty2 = 1'b0;
    for (int c = 0; c < 10 && !done2; c++) tick();
    chk("sat_block_done", 32'(done2), 32'd1);
    chk("sat_tokens_hold", 32'(tokens_read2), 32'd15);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      token_ready = ($urandom_range(0, 3) != 0);
      req         = ($urandom_range(0, 7) == 0);
      req_len     = 6'($urandom_range(0, 12));
      stat_clr    = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 2) != 0 && fq.size() < 32) begin
        fq.push_back(16'($urandom));
        fifo_drive();
      end
      tick();
    end
    req = 1'b0; stat_clr = 1'b0; token_ready = 1'b1;
    for (int c = 0; c < 200 && m_active; c++) begin
      if (fq.size() == 0) begin
        fq.push_back(16'($urandom));
        fifo_drive();
      end
      tick();
    end
    chk("rand_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
